// File: rtl/acc_insn_queue.sv
`default_nettype none
// ============================================================================
//  Module   : acc_insn_queue
//  Purpose  : In-order instruction FIFO between the issue stage and the
//             accelerator request channel, with an outstanding-request
//             counter that throttles issue at a configurable ceiling, plus
//             idle and flush support for the controller.
//  Revision : 1.0  initial release
// ============================================================================
module acc_insn_queue #(
   parameter int DEPTH           = 4,   // FIFO entries, power of two, >= 2
   parameter int MAX_OUTSTANDING = 4,   // accepted-but-unanswered ceiling, >= 1
   parameter int XLEN            = 64,  // operand width
   parameter int TRANS_ID_BITS   = 3    // scoreboard transaction id width
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic                                   flush_i,
   // issue side
   input  logic                                   issue_valid_i,
   output logic                                   issue_ready_o,
   input  logic [31:0]                            issue_insn_i,
   input  logic [XLEN-1:0]                        issue_rs1_i,
   input  logic [XLEN-1:0]                        issue_rs2_i,
   input  logic [2:0]                             issue_frm_i,
   input  logic [TRANS_ID_BITS-1:0]               issue_trans_id_i,
   // accelerator request side
   output logic                                   acc_req_valid_o,
   input  logic                                   acc_req_ready_i,
   output logic [31:0]                            acc_insn_o,
   output logic [XLEN-1:0]                        acc_rs1_o,
   output logic [XLEN-1:0]                        acc_rs2_o,
   output logic [2:0]                             acc_frm_o,
   output logic [TRANS_ID_BITS-1:0]               acc_trans_id_o,
   // accelerator response side
   input  logic                                   acc_resp_valid_i,
   output logic                                   acc_resp_ready_o,
   // status
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
   output logic                                   idle_o,
   output logic                                   spurious_resp_o
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = $clog2(DEPTH + 1);
   localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);
   localparam int ENTRY_W = 32 + 2 * XLEN + 3 + TRANS_ID_BITS;

   localparam logic [CNT_W-1:0] c_depth    = CNT_W'(DEPTH);
   localparam logic [OUT_W-1:0] c_max_out  = OUT_W'(MAX_OUTSTANDING);

   // Entry layout (MSB..LSB): insn | rs1 | rs2 | frm | trans_id
   logic [ENTRY_W-1:0] r_mem [DEPTH];

   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic [OUT_W-1:0]   r_outstanding;
   logic               r_spurious;

   logic               w_enq;
   logic               w_deq;
   logic               w_resp_ok;
   logic               w_write;
   logic [ENTRY_W-1:0] w_wr_entry;
   logic [ENTRY_W-1:0] w_head;

   // Handshake qualifiers; all flow control derives from registered state only
   assign issue_ready_o   = (r_count != c_depth);
   assign acc_req_valid_o = (r_count != '0) && (r_outstanding < c_max_out);
   assign w_enq           = issue_valid_i && issue_ready_o;
   assign w_deq           = acc_req_valid_o && acc_req_ready_i;
   assign w_resp_ok       = acc_resp_valid_i && (r_outstanding != '0);
   // A push coinciding with a flush is discarded entirely
   assign w_write         = w_enq && !flush_i;

   assign w_wr_entry = {issue_insn_i, issue_rs1_i, issue_rs2_i, issue_frm_i, issue_trans_id_i};
   // Data ports are zeroed whenever no request is presented
   assign w_head     = acc_req_valid_o ? r_mem[r_rd_ptr] : '0;

   assign acc_insn_o       = w_head[ENTRY_W-1 -: 32];
   assign acc_rs1_o        = w_head[3 + TRANS_ID_BITS + 2*XLEN - 1 -: XLEN];
   assign acc_rs2_o        = w_head[3 + TRANS_ID_BITS + XLEN - 1 -: XLEN];
   assign acc_frm_o        = w_head[TRANS_ID_BITS + 2 -: 3];
   assign acc_trans_id_o   = w_head[TRANS_ID_BITS-1:0];

   assign acc_resp_ready_o = 1'b1;
   assign outstanding_o    = r_outstanding;
   assign spurious_resp_o  = r_spurious;
   assign idle_o           = (r_count == '0) && (r_outstanding == '0);

   // Storage write; the array is deliberately left unreset
   always_ff @(posedge clk_i) begin
      if (w_write) begin
         r_mem[r_wr_ptr] <= w_wr_entry;
      end
   end

   // Pointers and occupancy; flush empties the queue by snapping rd onto wr
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush_i) begin
         r_rd_ptr <= r_wr_ptr;
         r_count  <= '0;
      end else begin
         if (w_enq) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_deq) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Outstanding counter; an issued request survives a flush until answered
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_outstanding <= '0;
      end else begin
         case ({w_deq, w_resp_ok})
            2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
            2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   // One-cycle flag for a response that arrives with nothing outstanding
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_spurious <= 1'b0;
      end else begin
         r_spurious <= acc_resp_valid_i && (r_outstanding == '0);
      end
   end

endmodule
`default_nettype wire

// File: doc/acc_insn_queue.md
Name: acc_insn_queue

Overview:
Buffers instructions that the issue stage offloads to the accelerator, then presents them on the accelerator request channel (req_valid/req_ready, insn, rs1, rs2, frm, trans_id) in program order. Counts accelerator requests that are issued but not yet answered, and throttles issue at a configurable ceiling. Sits between the CVA6 issue/scoreboard stage and the accelerator request/response structs. It also provides idle and flush support for the controller.

Parameters:
Depth, 4, number of FIFO entries (power of two, >=2)
MaxOutstanding, 4, max accelerator requests accepted but unanswered (>=1)
XLEN, 64, operand width
TransIdBits, 3, transaction id width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  discard all queued, not-yet-issued entries
issue_valid_i  in  1  offload request valid
issue_ready_o  out  1  queue can accept
issue_insn_i  in  32  instruction
issue_rs1_i  in  XLEN  operand 1
issue_rs2_i  in  XLEN  operand 2
issue_frm_i  in  3  FP rounding mode
issue_trans_id_i  in  TransIdBits  scoreboard id
acc_req_valid_o  out  1  request to accelerator
acc_req_ready_i  in  1  accelerator accepts (resp.req_ready)
acc_insn_o  out  32  head instruction
acc_rs1_o  out  XLEN  head operand 1
acc_rs2_o  out  XLEN  head operand 2
acc_frm_o  out  3  head rounding mode
acc_trans_id_o  out  TransIdBits  head id
acc_resp_valid_i  in  1  accelerator response valid
acc_resp_ready_o  out  1  response accepted (tied 1)
outstanding_o  out  $clog2(MaxOutstanding+1)  unanswered request count
idle_o  out  1  queue empty and nothing outstanding
spurious_resp_o  out  1  one-cycle pulse: response with count 0

Behaviour:
- Reset (rst_i high at a clock edge): read/write pointers 0, occupancy 0, outstanding 0, spurious_resp_o 0. Outputs after reset: issue_ready_o 1, acc_req_valid_o 0, acc_* data 0, idle_o 1, acc_resp_ready_o 1. Storage array is not reset. Reset mid-operation drops all entries and all outstanding count immediately.
- Enqueue: issue_valid_i && issue_ready_o. issue_ready_o = (occupancy != Depth). It depends only on registered occupancy; there is no same-cycle bypass when full, even if a dequeue happens.
- Latency: an entry written at edge N is presented at acc_* from cycle N+1. There is no combinational path from issue_* to acc_*.
- Dequeue: acc_req_valid_o = (occupancy != 0) && (outstanding_o < MaxOutstanding). A handshake is acc_req_valid_o && acc_req_ready_i. On a handshake, rd_ptr increments and outstanding increments.
- acc_* data ports show the head entry while acc_req_valid_o is high and are driven 0 otherwise. Once valid is asserted, head data is stable until the handshake.
- Pointers wrap modulo Depth. Simultaneous enqueue and dequeue leaves occupancy unchanged.
- Response: acc_resp_valid_i with outstanding>0 decrements outstanding. A response in the same cycle as a dequeue handshake leaves the count unchanged. A response arriving at count 0 leaves the count at 0 and pulses spurious_resp_o for exactly one cycle (registered).
- Ceiling: at outstanding == MaxOutstanding, valid is held low. A response in that cycle re-enables valid the following cycle.
- flush_i: at the edge, occupancy is set to 0 and rd_ptr is set to wr_ptr. A same-cycle enqueue is dropped. A same-cycle dequeue handshake still counts as issued (outstanding increments). Outstanding is not cleared by a flush.
- idle_o = (occupancy == 0) && (outstanding_o == 0), combinational from registers.

Test Plan:
- Reset then enqueue insn 0x0000_0057, trans_id 2, with acc_req_ready_i=1 -> acc_req_valid_o high on the next cycle with matching fields; outstanding_o goes 0->1; idle_o=0.
- Fill with 4 entries (Depth=4) while acc_req_ready_i=0 -> issue_ready_o=0 after the 4th; a 5th push is ignored; drain returns the ids in order 0,1,2,3 and pointers wrap correctly on the refill.
- With MaxOutstanding=2, issue 3 entries with no responses -> only 2 handshakes and valid=0; one response -> the 3rd issues the next cycle and outstanding_o stays 2.
- Same-cycle dequeue and response at outstanding=1 -> outstanding_o remains 1.
- 3 entries queued, flush_i while the head handshakes with a same-cycle push -> occupancy 0, outstanding +1, pushed entry absent, idle_o=0 until the response.
- acc_resp_valid_i at outstanding 0 -> spurious_resp_o=1 for exactly one cycle; counter stays 0; reset asserted mid-burst -> all outputs return to their reset values the next cycle.
